key_inject_sched: RTL and testbench
===================================

KEY_INJECT_SCHED -- requirements
Module: key_inject_sched

Interface
REQ-001 Parameter HOLD_TICKS, default 3, number of tick pulses a key stays pressed (legal 1..255).
REQ-002 Parameter GAP_TICKS, default 2, number of tick pulses of all-released gap after each key (legal 0..255).
REQ-003 Parameter FIFO_DEPTH, default 8, code FIFO entries (power of two, 2..32).
REQ-004 clk  in  1  system clock; the block has one clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  one-cycle pacing strobe (frame rate).
REQ-007 in_valid  in  1  code offered.
REQ-008 in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
REQ-009 in_code  in  8  bit7 shift, [6:3] matrix row, [2:0] column.
REQ-010 Y  in  4  row currently scanned by the PPI.
REQ-011 X_inj  out  8  active-high press mask for row Y, ORed by the top level into the matrix before inversion.
REQ-012 user_active  in  1  physical keyboard/joystick activity.
REQ-013 abort  in  1  synchronous flush request.
REQ-014 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT_PRE, PRESS, GAP.
REQ-016 In IDLE with the FIFO non-empty, the head SHALL be popped and latched; next state SHIFT_PRE if bit7 set, else PRESS.
REQ-017 A popped code with row > 9 SHALL be discarded; the FSM stays IDLE and the next head may pop on the following cycle.
REQ-018 SHIFT_PRE SHALL assert only shift (row 2, col 5) and exit to PRESS on the first tick.
REQ-019 PRESS SHALL assert the latched key, plus shift if bit7, and exit after HOLD_TICKS ticks; the exiting tick is the HOLD_TICKS-th tick.
REQ-020 GAP SHALL assert nothing and exit to IDLE after GAP_TICKS ticks; GAP_TICKS=0 SHALL go directly from PRESS to IDLE.
REQ-021 A tick in any cycle spent in a state SHALL count, including the entry cycle; the 8-bit tick counter SHALL clear on every state change.
REQ-022 X_inj SHALL be combinational from registered state and Y: bit col when Y==row; bit 5 when Y==2 and shift is asserted; all other rows 0.
REQ-023 When key row is 2 and col is 5 with shift, X_inj for Y=2 SHALL be 0x20 (bits merge).
REQ-024 in_ready SHALL be low when the FIFO is full or abort is high, even if a pop occurs in the same cycle.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count unchanged and preserve order.
REQ-026 abort SHALL empty the FIFO and force IDLE on the next edge; X_inj SHALL be 0 from the following cycle.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use an extra wrap bit.

Reset
REQ-028 Reset SHALL asynchronously clear the FIFO pointers, the FSM (to IDLE), the counter and the latched code; X_inj=0, busy=0, in_ready=1 while in reset and after it.
REQ-029 Reset mid-PRESS SHALL release the key immediately without entering GAP.

Configuration
REQ-030 With KEY_INJECT_PREEMPT_EN defined, user_active high SHALL force X_inj=0, freeze the counter (ticks ignored), and block pops; state and FIFO are kept, and activity resumes when user_active falls.
REQ-031 Without KEY_INJECT_PREEMPT_EN, user_active SHALL be ignored.

Verification
REQ-032 HOLD=2, GAP=1, push 0x45 -> next cycle Y=8 gives X_inj=0x20 for 2 ticks, then 0 for 1 tick, then busy=0.
REQ-033 Push 0xC5 -> Y=2 gives 0x20 and Y=8 gives 0x00 until tick 1; then Y=8 gives 0x20 and Y=2 gives 0x20 for HOLD ticks.
REQ-034 No ticks, push continuously -> 9 codes accepted (8 queued plus 1 latched); in_ready=0 on the 10th; order is preserved on playback.
REQ-035 Push 0x7F then 0x08 -> 0x7F dropped with no gap; Y=1 gives X_inj=0x01 one cycle later.
REQ-036 abort during PRESS with 3 queued -> X_inj=0 and busy=0 two cycles later; async reset mid-PRESS -> X_inj=0 immediately.
REQ-037 With KEY_INJECT_PREEMPT_EN, user_active=1 for 5 ticks mid-PRESS -> X_inj=0 and the hold count resumes afterwards; without the macro, no effect.

Source files
------------

// File: rtl/key_inject_sched_if.sv
// Code-offer handshake between a key-code producer and key_inject_sched.
interface key_inject_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/key_inject_sched.sv
// Key-injection scheduler: queues matrix key codes and replays them as tick-paced presses.
// Optional KEY_INJECT_PREEMPT_EN: physical user activity suspends injection.
module key_inject_sched #(
  parameter int unsigned HOLD_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  key_inject_sched_if.slave        in_if,
  input  logic [3:0]               Y,
  output logic [7:0]               X_inj,
  input  logic                     user_active,
  input  logic                     abort,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TICKS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT_PRE = 2'd1;
  localparam logic [1:0] PRESS     = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  logic        hold_off;
`ifdef KEY_INJECT_PREEMPT_EN
  assign hold_off = user_active;
`else
  logic unused_user_active;
  assign unused_user_active = user_active;
  assign hold_off = 1'b0;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;
  logic [7:0]  head;
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  code_q, code_d;
  logic        tick_en;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  assign in_if.in_ready = !full && !abort;
  assign push    = in_if.in_valid && in_if.in_ready;
  assign pop     = (state_q == IDLE) && !empty && !abort && !hold_off;
  assign tick_en = tick && !hold_off;
  assign busy    = !empty || (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_if.in_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (abort) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        // Rows above 9 do not exist in the matrix; such codes are dropped here.
        if (pop) begin
          code_d = head;
          if (head[6:3] <= 4'd9) state_d = head[7] ? SHIFT_PRE : PRESS;
        end
      end
      SHIFT_PRE: if (tick_en) state_d = PRESS;
      PRESS: begin
        if (tick_en) begin
          if (cnt_q == HOLD_LAST) state_d = (GAP_TICKS == 0) ? IDLE : GAP;
          else                    cnt_d   = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (tick_en) begin
          if (cnt_q == GAP_LAST) state_d = IDLE;
          else                   cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    X_inj = '0;
    if (!hold_off) begin
      if (state_q == PRESS && Y == code_q[6:3]) X_inj[code_q[2:0]] = 1'b1;
      // Shift lives at row 2, column 5 and merges with a key on the same row.
      if (Y == 4'd2 && (state_q == SHIFT_PRE || (state_q == PRESS && code_q[7])))
        X_inj[5] = 1'b1;
    end
  end

endmodule

// File: tb/tb_key_inject_sched.sv
// Scoreboard bench for key_inject_sched (HOLD_TICKS=2, GAP_TICKS=1, FIFO_DEPTH=8).
module tb_key_inject_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       user_active = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] Y;
  logic [7:0] X_inj;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [3:0] y;
    logic [7:0] x;
    logic       busy;
    logic       rdy;
  } chk_t;

  chk_t exp_q[$];

  key_inject_sched_if ifc ();

  key_inject_sched #(
    .HOLD_TICKS (2),
    .GAP_TICKS  (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .in_if       (ifc),
    .Y           (Y),
    .X_inj       (X_inj),
    .user_active (user_active),
    .abort       (abort),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic push_code(input logic [7:0] c);
    ifc.in_valid = 1'b1;
    ifc.in_code  = c;
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic exp_out(input string name, input logic [3:0] y, input logic [7:0] x,
                         input logic b, input logic r);
    chk_t e;
    e.name = name;
    e.y    = y;
    e.x    = x;
    e.busy = b;
    e.rdy  = r;
    exp_q.push_back(e);
  endtask

  // Monitor: owns Y, evaluates every queued expectation in the low clock phase.
  initial begin : monitor
    chk_t e;
    Y = 4'd0;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        Y = e.y;
        #1;
        n_checks++;
        if ({X_inj, busy, ifc.in_ready} !== {e.x, e.busy, e.rdy}) begin
          n_errors++;
          $display("FAIL %s (Y=%0d): got x_inj=%02h busy=%b in_ready=%b, want x_inj=%02h busy=%b in_ready=%b",
                   e.name, e.y, X_inj, busy, ifc.in_ready, e.x, e.busy, e.rdy);
        end
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin : watchdog
    #200000;
    n_errors++;
    $display("FAIL watchdog: stimulus did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  logic [7:0] codes [9];

  initial begin : stim
    ifc.in_valid = 1'b0;
    ifc.in_code  = 8'h00;
    for (int i = 0; i < 9; i++) codes[i] = 8'((i << 3) | (i & 7));

    // Reset
    step();
    n_checks++;
    if ({X_inj, busy, ifc.in_ready} !== {8'h00, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_direct: got x_inj=%02h busy=%b in_ready=%b", X_inj, busy,
               ifc.in_ready);
    end
    exp_out("reset_hold", 4'd0, 8'h00, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    exp_out("after_reset", 4'd0, 8'h00, 1'b0, 1'b1);
    step();

    // 0x45: row 8 col 5, two held ticks then one gap tick
    push_code(8'h45);
    exp_out("t1_queued", 4'd8, 8'h00, 1'b1, 1'b1);
    step();
    exp_out("t1_press0", 4'd8, 8'h20, 1'b1, 1'b1);
    exp_out("t1_other_row", 4'd2, 8'h00, 1'b1, 1'b1);
    tick_step();
    exp_out("t1_press1", 4'd8, 8'h20, 1'b1, 1'b1);
    tick_step();
    exp_out("t1_gap", 4'd8, 8'h00, 1'b1, 1'b1);
    tick_step();
    exp_out("t1_idle", 4'd8, 8'h00, 1'b0, 1'b1);
    step();

    // 0xC5: shifted row 8 col 5
    push_code(8'hC5);
    step();
    exp_out("t2_shift_pre", 4'd2, 8'h20, 1'b1, 1'b1);
    exp_out("t2_pre_key_off", 4'd8, 8'h00, 1'b1, 1'b1);
    tick_step();
    exp_out("t2_press_key", 4'd8, 8'h20, 1'b1, 1'b1);
    exp_out("t2_press_shift", 4'd2, 8'h20, 1'b1, 1'b1);
    tick_step();
    exp_out("t2_press_key1", 4'd8, 8'h20, 1'b1, 1'b1);
    tick_step();
    exp_out("t2_gap", 4'd2, 8'h00, 1'b1, 1'b1);
    tick_step();
    exp_out("t2_idle", 4'd8, 8'h00, 1'b0, 1'b1);

    // 0x95: shifted row 2 col 5 merges with shift
    push_code(8'h95);
    step();
    tick_step();
    exp_out("t3_merge", 4'd2, 8'h20, 1'b1, 1'b1);
    tick_step();
    tick_step();
    tick_step();
    exp_out("t3_idle", 4'd2, 8'h00, 1'b0, 1'b1);

    // 0x7F (row 15) dropped, 0x08 follows without a gap
    push_code(8'h7F);
    push_code(8'h08);
    exp_out("t4_dropped", 4'd1, 8'h00, 1'b1, 1'b1);
    step();
    exp_out("t4_press", 4'd1, 8'h01, 1'b1, 1'b1);
    exp_out("t4_bad_row", 4'd15, 8'h00, 1'b1, 1'b1);
    tick_step();
    tick_step();
    tick_step();
    exp_out("t4_idle", 4'd1, 8'h00, 1'b0, 1'b1);

    // No ticks: 9 codes accepted, 10th refused, order kept on playback
    for (int i = 0; i < 9; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_code  = codes[i];
      step();
      if (i == 7) exp_out("t5_not_full", 4'd0, 8'h01, 1'b1, 1'b1);
    end
    exp_out("t5_full", 4'd0, 8'h01, 1'b1, 1'b0);
    ifc.in_code = 8'h4F;
    step();
    ifc.in_valid = 1'b0;
    exp_out("t5_refused", 4'd0, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp_out($sformatf("t5_play%0d", i), codes[i][6:3], 8'(1 << codes[i][2:0]), 1'b1,
              (i == 0) ? 1'b0 : 1'b1);
      tick_step();
      tick_step();
      tick_step();
      if (i == 0) exp_out("t5_pop_pending", 4'd0, 8'h00, 1'b1, 1'b0);
      if (i < 8) step();
    end
    exp_out("t5_drained", 4'd9, 8'h00, 1'b0, 1'b1);
    step();

    // Abort during PRESS with three codes queued
    push_code(8'h1B);
    push_code(8'h09);
    push_code(8'h12);
    push_code(8'h24);
    exp_out("t6_press", 4'd3, 8'h08, 1'b1, 1'b1);
    step();
    abort = 1'b1;
    exp_out("t6_abort_rdy", 4'd3, 8'h08, 1'b1, 1'b0);
    step();
    abort = 1'b0;
    exp_out("t6_flushed", 4'd3, 8'h00, 1'b0, 1'b1);
    step();
    exp_out("t6_flushed2", 4'd1, 8'h00, 1'b0, 1'b1);
    step();

    // Asynchronous reset mid-PRESS
    push_code(8'h1B);
    step();
    exp_out("t7_press", 4'd3, 8'h08, 1'b1, 1'b1);
    step();
    reset = 1'b1;
    exp_out("t7_reset_now", 4'd3, 8'h00, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    exp_out("t7_after", 4'd3, 8'h00, 1'b0, 1'b1);
    step();

    // user_active mid-PRESS
    push_code(8'h1B);
    step();
    user_active = 1'b1;
`ifdef KEY_INJECT_PREEMPT_EN
    exp_out("t8_preempt", 4'd3, 8'h00, 1'b1, 1'b1);
    repeat (5) tick_step();
    exp_out("t8_frozen", 4'd3, 8'h00, 1'b1, 1'b1);
    user_active = 1'b0;
    exp_out("t8_resume", 4'd3, 8'h08, 1'b1, 1'b1);
    tick_step();
    exp_out("t8_hold1", 4'd3, 8'h08, 1'b1, 1'b1);
    tick_step();
    exp_out("t8_gap", 4'd3, 8'h00, 1'b1, 1'b1);
    tick_step();
`else
    exp_out("t8_ignored", 4'd3, 8'h08, 1'b1, 1'b1);
    tick_step();
    exp_out("t8_hold1", 4'd3, 8'h08, 1'b1, 1'b1);
    tick_step();
    exp_out("t8_gap", 4'd3, 8'h00, 1'b1, 1'b1);
    tick_step();
    user_active = 1'b0;
`endif
    exp_out("t8_idle", 4'd3, 8'h00, 1'b0, 1'b1);
    step();
    step();

    if (exp_q.size() != 0 || n_checks < 12) begin
      n_errors++;
      $display("FAIL drain: %0d expectations pending, %0d checks run", exp_q.size(), n_checks);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
